// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: sequences halt/stall/return flushes and interrupt entry for fetch/decode (optional PCU_IRQ_LATCH_EN).
// Latency: every output is registered; a request sampled on a falling clock edge drives the outputs from that edge on.
// Backpressure: none; blocked interrupts are deferred, and are held in irq_pending only when PCU_IRQ_LATCH_EN is defined.
module pipeline_control_unit #(
    parameter int ADDR_WIDTH = 14,
    parameter int NUM_IRQ    = 4,
    parameter int RET_FLUSH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  return_req,
    input  logic                  halt,
    input  logic                  fetch_stl_req,
    input  logic                  dec_stl_req,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic                  irq_enable,
    input  logic [ADDR_WIDTH-1:0] irq_vector_base,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic [2:0]            prog_cntr_load_sel,
    output logic                  inst_word_sel,
    output logic [31:0]           new_inst_word,
    output logic [ADDR_WIDTH-1:0] prog_cntr_int_addr,
    output logic [NUM_IRQ-1:0]    irq_ack,
    output logic [NUM_IRQ-1:0]    irq_pending,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        ST_NORMAL       = 4'd0,
        ST_HALT         = 4'd1,
        ST_INTERRUPT    = 4'd2,
        ST_STALL_FETCH  = 4'd3,
        ST_STALL_DECODE = 4'd4,
        ST_RETURN       = 4'd5
    } state_t;

    localparam logic [2:0] SEL_HOLD = 3'b000;
    localparam logic [2:0] SEL_INC  = 3'b001;
    localparam logic [2:0] SEL_VEC  = 3'b010;
    localparam logic [3:0] FLUSH_INIT = 4'(RET_FLUSH - 1);

    state_t                  state_q, state_d;
    logic                    stall_fetch_q, stall_fetch_d;
    logic                    stall_decode_q, stall_decode_d;
    logic [2:0]              sel_q, sel_d;
    logic                    iws_q, iws_d;
    logic [31:0]             word_q, word_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NUM_IRQ-1:0]      ack_q, ack_d;
    logic [3:0]              flush_cnt_q, flush_cnt_d;
    logic                    flush_tail_q, flush_tail_d;

    logic [NUM_IRQ-1:0]      irq_active;
    logic [NUM_IRQ-1:0]      irq_onehot;
    logic [2:0]              irq_id;
    logic                    irq_found;
    logic                    irq_take;
    logic [ADDR_WIDTH-1:0]   vec_addr;
    logic [31:0]             inj_word;
    logic                    enter_irq;
    logic [2:0]              enter_sel;

`ifdef PCU_IRQ_LATCH_EN
    logic [NUM_IRQ-1:0]      pending_q, pending_d;

    always_comb begin
        irq_active = pending_q | irq;
    end
`else
    always_comb begin
        irq_active = irq;
    end
`endif

    // Lowest set line wins; its index selects the vector table slot.
    always_comb begin
        irq_id     = 3'd0;
        irq_onehot = '0;
        irq_found  = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_active[i] && !irq_found) begin
                irq_found     = 1'b1;
                irq_id        = 3'(i);
                irq_onehot[i] = 1'b1;
            end
        end
        irq_take = irq_enable && irq_found;
        vec_addr = irq_vector_base + ADDR_WIDTH'({irq_id, 2'b00});
        inj_word = 32'h0000_0042 | (32'(vec_addr) << (32 - ADDR_WIDTH));
    end

    always_comb begin
        state_d        = ST_NORMAL;
        stall_fetch_d  = 1'b0;
        stall_decode_d = 1'b0;
        sel_d          = SEL_INC;
        iws_d          = 1'b0;
        word_d         = '0;
        addr_d         = '0;
        ack_d          = '0;
        flush_cnt_d    = '0;
        flush_tail_d   = 1'b0;
        enter_irq      = 1'b0;
        enter_sel      = SEL_VEC;

        case (state_q)
            ST_NORMAL: begin
                if (return_req) begin
                    state_d       = ST_RETURN;
                    stall_fetch_d = 1'b1;
                    sel_d         = SEL_HOLD;
                    flush_cnt_d   = FLUSH_INIT;
                end else if (halt) begin
                    state_d        = ST_HALT;
                    stall_fetch_d  = 1'b1;
                    stall_decode_d = 1'b1;
                    iws_d          = 1'b1;
                end else if (fetch_stl_req) begin
                    state_d       = ST_STALL_FETCH;
                    stall_fetch_d = 1'b1;
                    iws_d         = 1'b1;
                end else if (dec_stl_req) begin
                    state_d       = ST_STALL_DECODE;
                    stall_fetch_d = 1'b1;
                    sel_d         = SEL_HOLD;
                    iws_d         = 1'b1;
                end else if (irq_take) begin
                    enter_irq = 1'b1;
                    enter_sel = SEL_HOLD;
                end
            end
            ST_HALT: begin
                if (irq_take) begin
                    enter_irq = 1'b1;
                end else begin
                    state_d        = ST_HALT;
                    stall_fetch_d  = 1'b1;
                    stall_decode_d = 1'b1;
                    iws_d          = 1'b1;
                end
            end
            ST_STALL_FETCH, ST_STALL_DECODE: begin
                enter_irq = irq_take;
            end
            ST_RETURN: begin
                // The tail flag adds one cycle after the counter hits zero.
                if (!(flush_cnt_q == 4'd0 && flush_tail_q)) begin
                    state_d       = ST_RETURN;
                    stall_fetch_d = 1'b1;
                    iws_d         = 1'b1;
                    if (flush_cnt_q != 4'd0) begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end else begin
                        flush_tail_d = 1'b1;
                    end
                end
            end
            ST_INTERRUPT: begin
            end
            default: begin
            end
        endcase

        if (enter_irq) begin
            state_d        = ST_INTERRUPT;
            stall_fetch_d  = 1'b1;
            stall_decode_d = 1'b0;
            sel_d          = enter_sel;
            iws_d          = 1'b1;
            word_d         = inj_word;
            addr_d         = vec_addr;
            ack_d          = irq_onehot;
        end
    end

`ifdef PCU_IRQ_LATCH_EN
    // An acknowledge clears the line even if it is re-asserted in the same cycle.
    always_comb begin
        pending_d = (pending_q | irq) & ~ack_d;
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign irq_pending = pending_q;
`else
    assign irq_pending = '0;
`endif

    always_ff @(negedge clock) begin
        if (reset) begin
            state_q        <= ST_NORMAL;
            stall_fetch_q  <= 1'b0;
            stall_decode_q <= 1'b0;
            sel_q          <= SEL_INC;
            iws_q          <= 1'b0;
            word_q         <= '0;
            addr_q         <= '0;
            ack_q          <= '0;
            flush_cnt_q    <= '0;
            flush_tail_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            stall_fetch_q  <= stall_fetch_d;
            stall_decode_q <= stall_decode_d;
            sel_q          <= sel_d;
            iws_q          <= iws_d;
            word_q         <= word_d;
            addr_q         <= addr_d;
            ack_q          <= ack_d;
            flush_cnt_q    <= flush_cnt_d;
            flush_tail_q   <= flush_tail_d;
        end
    end

    assign stall_fetch        = stall_fetch_q;
    assign stall_decode       = stall_decode_q;
    assign prog_cntr_load_sel = sel_q;
    assign inst_word_sel      = iws_q;
    assign new_inst_word      = word_q;
    assign prog_cntr_int_addr = addr_q;
    assign irq_ack            = ack_q;
    assign state              = state_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed scenarios then random traffic against a behavioural model.
// Inputs change just after each falling edge; outputs are compared 1 time unit after that edge.
module tb_pipeline_control_unit;

    localparam int AW = 14;
    localparam int NI = 4;
    localparam int RF = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          return_req, halt, fetch_stl_req, dec_stl_req;
    logic [NI-1:0] irq;
    logic          irq_enable;
    logic [AW-1:0] irq_vector_base;
    logic          stall_fetch, stall_decode;
    logic [2:0]    prog_cntr_load_sel;
    logic          inst_word_sel;
    logic [31:0]   new_inst_word;
    logic [AW-1:0] prog_cntr_int_addr;
    logic [NI-1:0] irq_ack, irq_pending;
    logic [3:0]    state;

    int checks = 0;
    int errors = 0;

    // Reference model state: a state number, the count of RETURN cycles still to come, the pending set.
    int            m_state;
    int            m_ret_left;
    logic [NI-1:0] m_pend;
    logic          e_sf, e_sd, e_iws;
    logic [2:0]    e_sel;
    logic [31:0]   e_word;
    logic [AW-1:0] e_addr;
    logic [NI-1:0] e_ack;

    pipeline_control_unit #(.ADDR_WIDTH(AW), .NUM_IRQ(NI), .RET_FLUSH(RF)) dut (
        .clock(clock), .reset(reset),
        .return_req(return_req), .halt(halt),
        .fetch_stl_req(fetch_stl_req), .dec_stl_req(dec_stl_req),
        .irq(irq), .irq_enable(irq_enable), .irq_vector_base(irq_vector_base),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .prog_cntr_load_sel(prog_cntr_load_sel), .inst_word_sel(inst_word_sel),
        .new_inst_word(new_inst_word), .prog_cntr_int_addr(prog_cntr_int_addr),
        .irq_ack(irq_ack), .irq_pending(irq_pending), .state(state)
    );

    always #5 clock = ~clock;

    function automatic void model_step();
        logic [NI-1:0] act;
        int            id;
        int            intr_sel;
        logic [AW-1:0] v;
        logic [31:0]   w;
`ifdef PCU_IRQ_LATCH_EN
        act = m_pend | irq;
`else
        act = irq;
`endif
        id = -1;
        for (int i = NI - 1; i >= 0; i--) if (act[i]) id = i;
        intr_sel = -1;
        e_sf = 0; e_sd = 0; e_sel = 3'd1; e_iws = 0; e_word = 0; e_addr = 0; e_ack = 0;
        if (reset) begin
            m_state = 0; m_ret_left = 0; m_pend = 0;
        end else begin
            case (m_state)
                0: begin
                    if (return_req) begin
                        m_state = 5; e_sf = 1; e_sel = 3'd0; m_ret_left = RF;
                    end else if (halt) begin
                        m_state = 1; e_sf = 1; e_sd = 1; e_iws = 1;
                    end else if (fetch_stl_req) begin
                        m_state = 3; e_sf = 1; e_iws = 1;
                    end else if (dec_stl_req) begin
                        m_state = 4; e_sf = 1; e_sel = 3'd0; e_iws = 1;
                    end else if (irq_enable && id >= 0) begin
                        intr_sel = 0;
                    end else begin
                        m_state = 0;
                    end
                end
                1: begin
                    if (irq_enable && id >= 0) intr_sel = 2;
                    else begin e_sf = 1; e_sd = 1; e_iws = 1; end
                end
                3, 4: begin
                    if (irq_enable && id >= 0) intr_sel = 2;
                    else m_state = 0;
                end
                5: begin
                    if (m_ret_left == 0) m_state = 0;
                    else begin
                        m_ret_left--; e_sf = 1; e_iws = 1;
                    end
                end
                default: m_state = 0;
            endcase
            if (intr_sel >= 0) begin
                m_state = 2; e_sf = 1; e_iws = 1; e_sel = 3'(intr_sel);
                v = irq_vector_base + AW'(4 * id);
                w = 32'(v);
                e_addr = v;
                e_word = 32'h42 | (w << (32 - AW));
                e_ack = NI'(1) << id;
            end
`ifdef PCU_IRQ_LATCH_EN
            m_pend = (m_pend | irq) & ~e_ack;
`else
            m_pend = '0;
`endif
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".stall_fetch"}, 32'(stall_fetch), 32'(e_sf));
        chk({tag, ".stall_decode"}, 32'(stall_decode), 32'(e_sd));
        chk({tag, ".sel"}, 32'(prog_cntr_load_sel), 32'(e_sel));
        chk({tag, ".inst_word_sel"}, 32'(inst_word_sel), 32'(e_iws));
        chk({tag, ".new_inst_word"}, new_inst_word, e_word);
        chk({tag, ".int_addr"}, 32'(prog_cntr_int_addr), 32'(e_addr));
        chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(e_ack));
        chk({tag, ".irq_pending"}, 32'(irq_pending), 32'(m_pend));
    endtask

    task automatic tick(input string tag);
        @(negedge clock);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        int   n5;
        logic sf_ok;
        m_state = 0; m_ret_left = 0; m_pend = '0;
        reset = 1; return_req = 0; halt = 0; fetch_stl_req = 0; dec_stl_req = 0;
        irq = '0; irq_enable = 0; irq_vector_base = '0;

        tick("reset");
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_sel", 32'(prog_cntr_load_sel), 32'd1);
        reset = 0;
        tick("idle");

        // Reset in the middle of a return flush
        return_req = 1; tick("r035_enter");
        return_req = 0; tick("r035_cycle2");
        chk("r035_in_return", 32'(state), 32'd5);
        reset = 1; tick("r035_reset");
        chk("r035_state", 32'(state), 32'd0);
        chk("r035_stall_fetch", 32'(stall_fetch), 32'd0);
        chk("r035_iws", 32'(inst_word_sel), 32'd0);
        reset = 0; tick("r035_after");

        // Return flush length
        return_req = 1; tick("r036_enter");
        return_req = 0;
        n5 = (state == 4'd5) ? 1 : 0;
        sf_ok = stall_fetch;
        for (int i = 0; i < 8; i++) begin
            tick("r036_run");
            if (state == 4'd5) begin
                n5++;
                sf_ok = sf_ok & stall_fetch;
            end
        end
        chk("r036_cycles", 32'(n5), 32'd5);
        chk("r036_stall_fetch", 32'(sf_ok), 32'd1);
        chk("r036_final_state", 32'(state), 32'd0);

        // Halt then interrupt out of halt
        irq_enable = 1;
        halt = 1; tick("r037_halt");
        chk("r037_halt_state", 32'(state), 32'd1);
        halt = 0;
        for (int i = 0; i < 3; i++) tick("r037_hold");
        chk("r037_still_halt", 32'(state), 32'd1);
        irq = 4'b0110; irq_vector_base = 14'h0100; tick("r037_irq");
        chk("r037_state", 32'(state), 32'd2);
        chk("r037_ack", 32'(irq_ack), 32'b0010);
        chk("r037_vector", 32'(prog_cntr_int_addr), 32'h0104);
        chk("r037_sel", 32'(prog_cntr_load_sel), 32'b010);
        chk("r037_word", new_inst_word, 32'h0410_0042);
        irq = '0; tick("r037_exit");
        chk("r037_exit_state", 32'(state), 32'd0);
        reset = 1; tick("r037_reset");
        reset = 0; tick("r037_idle");

        // Halt beats fetch stall
        halt = 1; fetch_stl_req = 1; tick("r038_both");
        chk("r038_state", 32'(state), 32'd1);
        chk("r038_stall_decode", 32'(stall_decode), 32'd1);
        halt = 0; fetch_stl_req = 0; tick("r038_hold");
        reset = 1; tick("r038_reset");
        reset = 0; tick("r038_idle");

        // IRQ pulse during a return flush
        return_req = 1; tick("r039_enter");
        return_req = 0; tick("r039_ret1");
        irq = 4'b1000; tick("r039_pulse");
        irq = '0;
`ifdef PCU_IRQ_LATCH_EN
        chk("r039_pending", 32'(irq_pending), 32'b1000);
`else
        chk("r039_pending", 32'(irq_pending), 32'b0000);
`endif
        for (int i = 0; i < 3; i++) tick("r039_flush");
        chk("r039_normal", 32'(state), 32'd0);
        tick("r039_service");
`ifdef PCU_IRQ_LATCH_EN
        chk("r039_service_state", 32'(state), 32'd2);
        chk("r039_service_ack", 32'(irq_ack), 32'b1000);
`else
        chk("r039_service_state", 32'(state), 32'd0);
`endif
        tick("r039_settle");

        // Global enable gating
        irq_enable = 0; irq = 4'b0001;
        tick("r040_off1");
        tick("r040_off2");
        chk("r040_off_state", 32'(state), 32'd0);
        irq_enable = 1; tick("r040_on");
        chk("r040_on_state", 32'(state), 32'd2);
        chk("r040_on_ack", 32'(irq_ack), 32'b0001);
        irq = '0; tick("r040_exit");

        for (int c = 0; c < 400; c++) begin
            reset           = ($urandom_range(0, 39) == 0);
            return_req      = ($urandom_range(0, 11) == 0);
            halt            = ($urandom_range(0, 15) == 0);
            fetch_stl_req   = ($urandom_range(0, 7) == 0);
            dec_stl_req     = ($urandom_range(0, 7) == 0);
            irq             = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
            irq_enable      = ($urandom_range(0, 4) != 0);
            irq_vector_base = AW'($urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
